// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding imem request at a time,
// and buffers {pc, inst, fault} entries in a small FIFO toward decode/execute.
`timescale 1ns/1ps
module ifu_fetch #(
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter int unsigned           INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(64'h8000_0000),
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    input  logic                  imem_resp_err,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  out_fault
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ResetPc = {RESET_PC[ADDR_WIDTH-1:2], 2'b00};

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} fetchState_e;

    fetchState_e stateQ, stateD;
    logic [ADDR_WIDTH-1:0] fetchPcQ, fetchPcD;
    logic [ADDR_WIDTH-1:0] reqPcQ, reqPcD;
    logic [CntW-1:0]       countQ, countAfterPop, countNext;
    logic [PtrW-1:0]       rdPtrQ, wrPtrQ, rdPtrNext;

    logic [INST_WIDTH-1:0] fifoInst  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifoPc    [FIFO_DEPTH];
    logic                  fifoFault [FIFO_DEPTH];

    logic [INST_WIDTH-1:0] outInstQ, headInst;
    logic [ADDR_WIDTH-1:0] outPcQ, headPc;
    logic                  outFaultQ, headFault;

    logic reqFire, push, pop, credit, loadHead;
    logic unusedRedirectLsb;

    assign unusedRedirectLsb = ^redirect_pc[1:0];

    assign reqFire = (stateQ == StReq) && imem_req_ready;
    // A redirect voids both the push of the in-flight response and any same-cycle pop.
    assign push    = (stateQ == StWait) && imem_resp_valid && !redirect_valid;
    assign pop     = (countQ != '0) && out_ready && !redirect_valid;

    assign countAfterPop = countQ - CntW'(pop);
    assign countNext     = redirect_valid ? '0 : countAfterPop + CntW'(push);
    // Only called when nothing is outstanding afterwards, so count alone decides credit.
    assign credit        = countNext < Depth;
    assign rdPtrNext     = pop ? rdPtrQ + 1'b1 : rdPtrQ;
    assign loadHead      = !redirect_valid && (countNext != '0);

    always_comb begin
        stateD   = stateQ;
        fetchPcD = fetchPcQ;
        reqPcD   = reqPcQ;
        if (reqFire) begin
            fetchPcD = fetchPcQ + ADDR_WIDTH'(4);
            reqPcD   = fetchPcQ;
        end
        unique case (stateQ)
            StIdle: if (credit) stateD = StReq;
            StReq:  if (reqFire) stateD = StWait;
            StWait: if (imem_resp_valid) stateD = credit ? StReq : StIdle;
            StDrop: if (imem_resp_valid) stateD = StReq;
        endcase
        if (redirect_valid) begin
            fetchPcD = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            unique case (stateQ)
                StIdle:         stateD = StReq;
                StReq:          stateD = reqFire ? StDrop : StReq;
                StWait, StDrop: stateD = imem_resp_valid ? StReq : StDrop;
            endcase
        end
    end

    // Next head entry; an empty-after-pop FIFO takes the incoming response directly.
    always_comb begin
        headInst  = fifoInst[rdPtrNext];
        headPc    = fifoPc[rdPtrNext];
        headFault = fifoFault[rdPtrNext];
        if (countAfterPop == '0) begin
            headInst  = imem_resp_data;
            headPc    = reqPcQ;
            headFault = imem_resp_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ    <= StIdle;
            fetchPcQ  <= ResetPc;
            reqPcQ    <= ResetPc;
            countQ    <= '0;
            rdPtrQ    <= '0;
            wrPtrQ    <= '0;
            outInstQ  <= '0;
            outPcQ    <= '0;
            outFaultQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            fetchPcQ <= fetchPcD;
            reqPcQ   <= reqPcD;
            countQ   <= countNext;
            if (redirect_valid) begin
                rdPtrQ <= wrPtrQ;
            end else begin
                rdPtrQ <= rdPtrNext;
                if (push) wrPtrQ <= wrPtrQ + 1'b1;
            end
            if (loadHead) begin
                outInstQ  <= headInst;
                outPcQ    <= headPc;
                outFaultQ <= headFault;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoInst[wrPtrQ]  <= imem_resp_data;
            fifoPc[wrPtrQ]    <= reqPcQ;
            fifoFault[wrPtrQ] <= imem_resp_err;
        end
    end

    assign imem_req_valid = (stateQ == StReq);
    assign imem_req_addr  = fetchPcQ;
    assign out_valid      = (countQ != '0);
    assign out_inst       = outInstQ;
    assign out_pc         = outPcQ;
    assign out_fault      = outFaultQ;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: behavioural imem with configurable latency, plus a 32-bit
// instance used to check PC wrap from a top-of-memory reset vector.
`timescale 1ns/1ps
module tb_ifu_fetch;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        reqValid;
    logic [63:0] reqAddr;
    logic        memReady = 1'b1;
    logic        respValid = 1'b0;
    logic [31:0] respData = '0;
    logic        respErr = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirectPc = '0;
    logic        outValid;
    logic        outReady = 1'b1;
    logic [31:0] outInst;
    logic [63:0] outPc;
    logic        outFault;

    logic        r2Valid;
    logic [31:0] r2Addr;
    logic        resp2Valid = 1'b0;
    logic        o2Valid;
    logic [31:0] o2Inst;
    logic [31:0] o2Pc;
    logic        o2Fault;

    int checks = 0;
    int errors = 0;

    int          lat = 1;
    logic [63:0] errAddr = '1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [63:0] pendAddr = '0;
    logic        hs2 = 1'b0;

    logic [63:0] reqLog[$];
    logic [63:0] outPcLog[$];
    logic [31:0] outInstLog[$];
    logic        outFaultLog[$];
    logic [31:0] log2[$];

    ifu_fetch u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (reqValid),
        .imem_req_ready (memReady),
        .imem_req_addr  (reqAddr),
        .imem_resp_valid(respValid),
        .imem_resp_data (respData),
        .imem_resp_err  (respErr),
        .redirect_valid (redirect),
        .redirect_pc    (redirectPc),
        .out_valid      (outValid),
        .out_ready      (outReady),
        .out_inst       (outInst),
        .out_pc         (outPc),
        .out_fault      (outFault)
    );

    ifu_fetch #(
        .ADDR_WIDTH(32),
        .INST_WIDTH(32),
        .RESET_PC  (32'hFFFF_FFFC),
        .FIFO_DEPTH(2)
    ) u_dut32 (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (r2Valid),
        .imem_req_ready (1'b1),
        .imem_req_addr  (r2Addr),
        .imem_resp_valid(resp2Valid),
        .imem_resp_data (32'h0000_0013),
        .imem_resp_err  (1'b0),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .out_valid      (o2Valid),
        .out_ready      (1'b1),
        .out_inst       (o2Inst),
        .out_pc         (o2Pc),
        .out_fault      (o2Fault)
    );

    function automatic logic [31:0] memData(input logic [63:0] a);
        if (a == 64'h8000_0000) return 32'h0000_0413;
        return a[31:0] ^ 32'h1357_0000;
    endfunction

    // Memory and logging act on the falling edge, clear of the DUT's rising edge.
    always @(negedge clk) begin
        respValid = 1'b0;
        if (!rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (cnt == 1) begin
                    respValid = 1'b1;
                    respData  = memData(pendAddr);
                    respErr   = (pendAddr == errAddr);
                    pend      = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (reqValid && memReady) begin
                pend     = 1'b1;
                cnt      = lat;
                pendAddr = reqAddr;
                reqLog.push_back(reqAddr);
            end
            if (outValid && outReady && !redirect) begin
                outPcLog.push_back(outPc);
                outInstLog.push_back(outInst);
                outFaultLog.push_back(outFault);
            end
        end
    end

    always @(negedge clk) begin
        resp2Valid = hs2;
        hs2 = rst && r2Valid;
        if (!rst) begin
            hs2 = 1'b0;
            resp2Valid = 1'b0;
            log2.delete();
        end else if (r2Valid) begin
            log2.push_back(r2Addr);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clearLogs();
        reqLog.delete();
        outPcLog.delete();
        outInstLog.delete();
        outFaultLog.delete();
    endtask

    task automatic doReset();
        rst = 1'b0;
        redirect = 1'b0;
        tick(2);
        clearLogs();
        rst = 1'b1;
    endtask

    task automatic waitOuts(input int n, input string tag);
        int i = 0;
        while (outPcLog.size() < n && i < 300) begin
            tick(1);
            i++;
        end
        chk(tag, 64'(outPcLog.size() >= n), 64'd1);
    endtask

    task automatic waitReqs(input int n, input string tag);
        int i = 0;
        while (reqLog.size() < n && i < 300) begin
            tick(1);
            i++;
        end
        chk(tag, 64'(reqLog.size() >= n), 64'd1);
    endtask

    initial begin
        int stale;

        // Reset state
        tick(2);
        chk("rst_req_valid", 64'(reqValid), 64'd0);
        chk("rst_req_addr", reqAddr, 64'h8000_0000);
        chk("rst_out_valid", 64'(outValid), 64'd0);
        chk("rst_out_inst", 64'(outInst), 64'd0);
        chk("rst_out_pc", outPc, 64'd0);
        chk("rst_out_fault", 64'(outFault), 64'd0);
        chk("rst32_req_addr", 64'(r2Addr), 64'hFFFF_FFFC);

        // 1: zero-wait memory, one instruction every two cycles
        clearLogs();
        rst = 1'b1;
        tick(1);
        chk("t1_req_valid_c1", 64'(reqValid), 64'd1);
        chk("t1_req_addr_c1", reqAddr, 64'h8000_0000);
        tick(1);
        chk("t1_req_valid_c2", 64'(reqValid), 64'd0);
        chk("t1_out_valid_c2", 64'(outValid), 64'd0);
        tick(1);
        chk("t1_out_valid_c3", 64'(outValid), 64'd1);
        chk("t1_out_pc_c3", outPc, 64'h8000_0000);
        chk("t1_out_inst_c3", 64'(outInst), 64'h0000_0413);
        chk("t1_req_addr_c3", reqAddr, 64'h8000_0004);
        tick(1);
        chk("t1_out_valid_c4", 64'(outValid), 64'd0);
        tick(1);
        chk("t1_req_addr_c5", reqAddr, 64'h8000_0008);
        chk("t1_out_pc_c5", outPc, 64'h8000_0004);

        // 2: backpressure fills the FIFO, then drains in order
        outReady = 1'b0;
        doReset();
        tick(20);
        chk("t2_req_count", 64'(reqLog.size()), 64'd2);
        chk("t2_req0", reqLog[0], 64'h8000_0000);
        chk("t2_req1", reqLog[1], 64'h8000_0004);
        chk("t2_req_valid_full", 64'(reqValid), 64'd0);
        chk("t2_out_pc_head", outPc, 64'h8000_0000);
        outReady = 1'b1;
        waitOuts(2, "t2_drain_timeout");
        chk("t2_out0", outPcLog[0], 64'h8000_0000);
        chk("t2_out1", outPcLog[1], 64'h8000_0004);
        chk("t2_out1_inst", 64'(outInstLog[1]), 64'h9357_0004);
        waitReqs(3, "t2_resume_timeout");
        chk("t2_req2", reqLog[2], 64'h8000_0008);

        // 3: redirect while a 3-cycle response is in flight
        lat = 3;
        doReset();
        tick(2);
        redirect = 1'b1;
        redirectPc = 64'h8000_1000;
        tick(1);
        redirect = 1'b0;
        chk("t3_req_valid_drop", 64'(reqValid), 64'd0);
        waitOuts(2, "t3_out_timeout");
        chk("t3_req1", reqLog[1], 64'h8000_1000);
        chk("t3_out0", outPcLog[0], 64'h8000_1000);
        chk("t3_out0_inst", 64'(outInstLog[0]), 64'h9357_1000);
        chk("t3_out1", outPcLog[1], 64'h8000_1004);
        stale = 0;
        foreach (outPcLog[i]) if (outPcLog[i] == 64'h8000_0000) stale++;
        chk("t3_no_stale", 64'(stale), 64'd0);

        // 4: redirect coincident with the response
        lat = 1;
        doReset();
        tick(2);
        redirect = 1'b1;
        redirectPc = 64'h8000_0006;
        tick(1);
        redirect = 1'b0;
        chk("t4_req_valid", 64'(reqValid), 64'd1);
        chk("t4_req_addr", reqAddr, 64'h8000_0004);
        chk("t4_out_valid", 64'(outValid), 64'd0);
        waitOuts(1, "t4_out_timeout");
        chk("t4_out0", outPcLog[0], 64'h8000_0004);

        // 5: access fault on one fetch only
        errAddr = 64'h8000_0008;
        doReset();
        waitOuts(4, "t5_out_timeout");
        chk("t5_fault0", 64'(outFaultLog[0]), 64'd0);
        chk("t5_fault1", 64'(outFaultLog[1]), 64'd0);
        chk("t5_pc2", outPcLog[2], 64'h8000_0008);
        chk("t5_fault2", 64'(outFaultLog[2]), 64'd1);
        chk("t5_pc3", outPcLog[3], 64'h8000_000C);
        chk("t5_fault3", 64'(outFaultLog[3]), 64'd0);
        errAddr = '1;

        // 6: asynchronous reset mid-WAIT with a buffered entry
        outReady = 1'b0;
        doReset();
        tick(4);
        chk("t6_out_valid_pre", 64'(outValid), 64'd1);
        chk("t6_out_pc_pre", outPc, 64'h8000_0000);
        #1 rst = 1'b0;
        #1;
        chk("t6_req_valid", 64'(reqValid), 64'd0);
        chk("t6_req_addr", reqAddr, 64'h8000_0000);
        chk("t6_out_valid", 64'(outValid), 64'd0);
        chk("t6_out_pc", outPc, 64'd0);
        chk("t6_out_inst", 64'(outInst), 64'd0);
        tick(1);
        clearLogs();
        outReady = 1'b1;
        rst = 1'b1;
        tick(1);
        chk("t6_first_req_valid", 64'(reqValid), 64'd1);
        chk("t6_first_req_addr", reqAddr, 64'h8000_0000);
        tick(6);
        chk("t6_wrap_count", 64'(log2.size() >= 2), 64'd1);
        chk("t6_wrap_req0", 64'(log2[0]), 64'hFFFF_FFFC);
        chk("t6_wrap_req1", 64'(log2[1]), 64'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch stage directly upstream of the single-cycle decode/execute top. It owns the fetch PC and issues requests to instruction memory over a valid/ready request channel with variable-latency responses. Returned {pc, inst, fault} entries go into a small FIFO, which presents them to decode/execute with a valid/ready handshake. Redirects (jumps, branches, exceptions) flush the FIFO and drop any stale in-flight response.

Parameters:
ADDR_WIDTH, 64, width of PC and memory address
INST_WIDTH, 32, instruction width
RESET_PC, 64'h8000_0000, first fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset; asynchronous, active-low
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  ADDR_WIDTH  fetch address, always 4-byte aligned
imem_resp_valid  input  1  response valid; one-cycle pulse per accepted request
imem_resp_data  input  INST_WIDTH  fetched instruction
imem_resp_err  input  1  access fault for this response
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  ADDR_WIDTH  new fetch address; bits [1:0] ignored
out_valid  output  1  instruction available to decode
out_ready  input  1  decode consumes the head entry
out_inst  output  INST_WIDTH  head instruction
out_pc  output  ADDR_WIDTH  head PC
out_fault  output  1  head entry faulted

Behaviour:
- Reset (rst=0, asynchronous) takes effect immediately:
  - state=IDLE, fetch_pc=RESET_PC, FIFO count=0.
  - imem_req_valid=0, imem_req_addr=RESET_PC.
  - out_valid=0, out_inst=0, out_pc=0, out_fault=0.
  - Takes effect mid-operation too. Any in-flight response is lost.
- At most one outstanding memory request. Responses arriving in IDLE or REQ are ignored.
- Credit: a new request may issue only if count_next + outstanding < FIFO_DEPTH. A response therefore always has FIFO space.
- FSM states: IDLE, REQ, WAIT, DROP.
  - IDLE: imem_req_valid=0. Moves to REQ when credit is available. The first posedge after reset release always goes to REQ.
  - REQ: imem_req_valid=1, imem_req_addr=fetch_pc, both held stable until handshake. On valid&ready: fetch_pc <= fetch_pc+4 (mod 2^ADDR_WIDTH), go to WAIT.
  - WAIT: on imem_resp_valid, push {fetch-address, data, err} and go to REQ if credit remains after the push/pop, else IDLE.
  - DROP: on imem_resp_valid, discard the response and go to REQ.
- Throughput: with zero-wait memory (ready=1, response next cycle) there is one instruction every 2 cycles.
- Redirect (redirect_valid=1) has highest priority over every other event in the same cycle:
  - FIFO is flushed (count=0). Any same-cycle pop is void. out_valid=0 from the next cycle.
  - fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - Next state:
    - From REQ with the handshake in the same cycle: DROP, because the accepted request is stale.
    - From WAIT without imem_resp_valid: DROP.
    - From WAIT or DROP with imem_resp_valid in the same cycle: the response is discarded, go to REQ.
    - From DROP otherwise: stay in DROP.
    - From IDLE, or REQ without handshake: REQ, with the new address driven that cycle+1.
- Output side:
  - out_valid = (count != 0). out_inst/out_pc/out_fault come from the FIFO head and are registered.
  - Pop on out_valid && out_ready.
  - A push and pop in the same cycle keeps count. A push into an empty FIFO is visible on out_valid the next cycle (no bypass).
  - Entries leave in fetch order.
  - When out_valid=0 the outputs are don't-care, except at reset.
- Faults: out_fault mirrors imem_resp_err of that entry. Fetch continues sequentially after a fault; the execute stage decides to redirect.
- Full FIFO with out_ready=0: imem_req_valid stays 0 and no entry is overwritten.

Test Plan:
1. Reset release, memory ready=1 with 1-cycle latency, out_ready=1, mem[0x80000000]=0x00000413 -> req addr 0x80000000 in cycle 1 after release, out_valid=1 with out_pc=0x80000000 and out_inst=0x00000413 in cycle 3; subsequent requests to 0x80000004, 0x80000008 every 2 cycles.
2. out_ready=0 from reset -> exactly 2 requests are issued, count=2, then imem_req_valid stays 0 indefinitely. Raising out_ready -> pcs 0x80000000 and 0x80000004 emerge in order and fetching resumes at 0x80000008.
3. 3-cycle memory latency, redirect_valid with redirect_pc=0x80001000 one cycle after a request is accepted -> the stale response is dropped, the next request address is 0x80001000, and no output with out_pc=0x80000000 ever appears.
4. redirect_pc=0x80000006 asserted in the same cycle as imem_resp_valid -> the response is discarded, the next imem_req_addr is 0x80000004, and the FIFO is empty the following cycle.
5. imem_resp_err=1 only for 0x80000008 -> out_fault=1 only for out_pc=0x80000008; out_pc=0x8000000C follows with out_fault=0.
6. rst pulled low between clock edges while in WAIT -> all outputs go to reset values before the next edge. After release, the first request is to RESET_PC. With RESET_PC=0xFFFFFFFC and ADDR_WIDTH=32, the second address is 0x00000000.
